// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: operation
// encodings and the arbiter FSM state type.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_AND = 2'd0,
    MODE_OR  = 2'd1,
    MODE_ADD = 2'd2,
    MODE_SLT = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the response channel and the
// completed-operation counter. The master side is whoever issues
// operations and consumes results; the slave side is the arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 32);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_mode;
  logic             req0_b_invert;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_mode;
  logic             req1_b_invert;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_res;

  logic [15:0]      op_count;

  modport master (
    output req0_valid, req0_mode, req0_b_invert, req0_a, req0_b,
    output req1_valid, req1_mode, req1_b_invert, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_res, op_count
  );

  modport slave (
    input  req0_valid, req0_mode, req0_b_invert, req0_a, req0_b,
    input  req1_valid, req1_mode, req1_b_invert, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_res, op_count
  );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational ALU shared by both requesters: AND, OR,
// ADD/SUB and a signed set-less-than taken straight from the sign bit
// of a-b (no overflow correction).
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_invert,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  // Select the operation; carries out of the top bit are dropped.
  always_comb begin
    sum  = a + b;
    diff = a + ~b + WIDTH'(1);
    res  = '0;
    case (mode)
      MODE_AND: res = a & b;
      MODE_OR:  res = a | b;
      MODE_ADD: res = b_invert ? diff : sum;
      MODE_SLT: res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU. One operation
// is accepted in IDLE, its result is held in RESP until the consumer
// takes it, so at most one operation completes every two cycles.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);

  state_e                 state;
  logic                   last_grant;
  logic                   rsp_valid_q;
  logic                   rsp_id_q;
  logic [WIDTH-1:0]       rsp_res_q;
  logic [COUNT_WIDTH-1:0] op_count_q;

  logic                   grant_any;
  logic                   grant_sel;
  logic                   accept;
  logic [WIDTH-1:0]       sel_a;
  logic [WIDTH-1:0]       sel_b;
  logic                   sel_b_invert;
  logic [1:0]             sel_mode;
  logic [WIDTH-1:0]       alu_res;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept    = (state == ST_IDLE) & grant_any;
  end

  // Route the granted requester's operation into the shared ALU.
  always_comb begin
    sel_a        = grant_sel ? bus.req1_a        : bus.req0_a;
    sel_b        = grant_sel ? bus.req1_b        : bus.req0_b;
    sel_b_invert = grant_sel ? bus.req1_b_invert : bus.req0_b_invert;
    sel_mode     = grant_sel ? bus.req1_mode     : bus.req0_mode;
  end

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a        (sel_a),
    .b        (sel_b),
    .b_invert (sel_b_invert),
    .mode     (sel_mode),
    .res      (alu_res)
  );

  // Accept/hold/release FSM; result, owner, pointer and counter are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      op_count_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_res_q   <= alu_res;
            rsp_id_q    <= grant_sel;
            last_grant  <= grant_sel;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ready is offered only in IDLE, only to the granted side, and never during reset.
  always_comb begin
    bus.req0_ready = rst_n & accept & ~grant_sel;
    bus.req1_ready = rst_n & accept &  grant_sel;
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a cycle model predicts grants,
// results and the completion count; expected results go into a queue
// at acceptance and are compared while the DUT presents them.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  logic        grant_log[$];
  int          tests;
  int          fails;
  logic        m_busy;
  logic        m_last;
  logic [15:0] m_count;
  logic        hs_seen;
  logic        hs_id;
  logic [15:0] count_before;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written independently of the RTL.
  function automatic logic [31:0] alu_model(input logic [1:0] mode, input logic inv,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    case (mode)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return inv ? diff : a + b;
      default: return {31'd0, diff[31]};
    endcase
  endfunction

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  // Cycle model, evaluated mid-cycle before the next rising edge.
  task automatic monitor();
    logic any;
    logic g;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_count = '0;
      return;
    end
    checkOutput("op_count", 32'(bus.op_count), 32'(m_count));
    if (!m_busy) begin
      any = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) g = ~m_last;
      else g = bus.req1_valid;
      checkOutput("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
      checkOutput("req0_ready", 32'(bus.req0_ready), 32'(any && !g));
      checkOutput("req1_ready", 32'(bus.req1_ready), 32'(any && g));
      if (any) begin
        e.id = g;
        if (g) e.res = alu_model(bus.req1_mode, bus.req1_b_invert, bus.req1_a, bus.req1_b);
        else   e.res = alu_model(bus.req0_mode, bus.req0_b_invert, bus.req0_a, bus.req0_b);
        sb.push_back(e);
        grant_log.push_back(g);
        m_last  = g;
        m_busy  = 1'b1;
        hs_seen = 1'b1;
        hs_id   = g;
      end
    end else begin
      checkOutput("rsp_valid_resp", 32'(bus.rsp_valid), 32'd1);
      checkOutput("req0_ready_resp", 32'(bus.req0_ready), 32'd0);
      checkOutput("req1_ready_resp", 32'(bus.req1_ready), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        checkOutput("rsp_res", bus.rsp_res, sb[0].res);
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
        if (bus.rsp_ready) begin
          void'(sb.pop_front());
          m_count = m_count + 16'd1;
          m_busy  = 1'b0;
        end
      end
    end
  endtask

  // Advance one cycle: model at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Present one operation on a requester and hold it until it is accepted.
  task automatic applyStimulus(input int idx, input logic [1:0] mode, input logic inv,
                               input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    if (idx == 0) begin
      bus.req0_mode = mode; bus.req0_b_invert = inv; bus.req0_a = a; bus.req0_b = b;
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_mode = mode; bus.req1_b_invert = inv; bus.req1_a = a; bus.req1_b = b;
      bus.req1_valid = 1'b1;
    end
    hs_seen = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (hs_seen && (hs_id == idx[0])) done = 1'b1;
    end
    if (idx == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
    if (!done) checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    m_busy = 1'b0; m_last = 1'b1; m_count = '0;
    hs_seen = 1'b0; hs_id = 1'b0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_mode = 2'd0; bus.req0_b_invert = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b1; bus.req1_mode = 2'd0; bus.req1_b_invert = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with both requesters asking to prove ready is held low.
    #12;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("reset_rsp_res", bus.rsp_res, 32'd0);
    checkOutput("reset_op_count", 32'(bus.op_count), 32'd0);
    checkOutput("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
    checkOutput("reset_req1_ready", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single subtract from requester 0: 5 - 3.
    applyStimulus(0, 2'd2, 1'b1, 32'd5, 32'd3);
    checkOutput("first_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("first_rsp_res", bus.rsp_res, 32'd2);
    checkOutput("first_rsp_id", 32'(bus.rsp_id), 32'd0);
    step();
    checkOutput("first_op_count", 32'(bus.op_count), 32'd1);

    // Continuous contention after reset alternates 0,1,0,1.
    do_reset();
    grant_log.delete();
    bus.req0_mode = 2'd0; bus.req0_b_invert = 1'b0; bus.req0_a = 32'hF0F0_1234; bus.req0_b = 32'hFF00_0FF0;
    bus.req1_mode = 2'd1; bus.req1_b_invert = 1'b0; bus.req1_a = 32'h0F0F_0000; bus.req1_b = 32'h0000_00AA;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (8) step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) step();
    checkOutput("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      checkOutput($sformatf("rr_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Set-less-than corners, including the uncorrected overflow case.
    applyStimulus(1, 2'd3, 1'b0, 32'h0000_0001, 32'h0000_0002);
    checkOutput("slt_1_lt_2", bus.rsp_res, 32'd1);
    applyStimulus(1, 2'd3, 1'b1, 32'h0000_0002, 32'h0000_0001);
    checkOutput("slt_2_lt_1", bus.rsp_res, 32'd0);
    applyStimulus(0, 2'd3, 1'b0, 32'h8000_0000, 32'h0000_0001);
    checkOutput("slt_min_lt_1", bus.rsp_res, 32'd0);
    applyStimulus(0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    checkOutput("add_wrap", bus.rsp_res, 32'd0);
    step();

    // Backpressure: the held result must not move for five cycles.
    bus.rsp_ready = 1'b0;
    applyStimulus(1, 2'd2, 1'b0, 32'd100, 32'd23);
    count_before = m_count;
    bus.req0_mode = 2'd1; bus.req0_b_invert = 1'b0; bus.req0_a = 32'h00FF_0000; bus.req0_b = 32'h0000_FF00;
    bus.req0_valid = 1'b1;
    repeat (5) begin
      step();
      checkOutput("bp_rsp_res", bus.rsp_res, 32'd123);
      checkOutput("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
      checkOutput("bp_op_count", 32'(bus.op_count), 32'(count_before));
    end
    bus.rsp_ready = 1'b1;
    step();
    checkOutput("bp_release_idle", 32'(bus.rsp_valid), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    repeat (2) step();

    // Counter wrap: preload to the value 65535 completions would leave behind.
    force dut.op_count_q = 16'hFFFF;
    #1 release dut.op_count_q;
    m_count = 16'hFFFF;
    step();
    applyStimulus(0, 2'd2, 1'b0, 32'h1234_0000, 32'h0000_5678);
    step();
    checkOutput("op_count_wrap", 32'(bus.op_count), 32'd0);

    // Asynchronous reset while a result is being held.
    bus.rsp_ready = 1'b0;
    applyStimulus(1, 2'd0, 1'b0, 32'hAAAA_AAAA, 32'hFFFF_0000);
    bus.req0_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("async_op_count", 32'(bus.op_count), 32'd0);
    checkOutput("async_req0_ready", 32'(bus.req0_ready), 32'd0);
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req1_valid = 1'b1;
    hs_seen = 1'b0;
    step();
    checkOutput("post_reset_seen", 32'(hs_seen), 32'd1);
    checkOutput("post_reset_winner", 32'(hs_id), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 Port: req0_ready / req1_ready  output  1 each  arbiter accepts the requester-0/1 operation this cycle.
REQ-006 Port: req0_mode / req1_mode  input  2 each  operation: 0 AND, 1 OR, 2 ADD/SUB, 3 SLT.
REQ-007 Port: req0_b_invert / req1_b_invert  input  1 each  with mode 2, selects subtract.
REQ-008 Port: req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-009 Port: rsp_valid  output  1  result is held and valid.
REQ-010 Port: rsp_ready  input  1  consumer accepts the result.
REQ-011 Port: rsp_id  output  1  requester index that owns the result.
REQ-012 Port: rsp_res  output  WIDTH  operation result.
REQ-013 Port: op_count  output  16  count of completed responses, wraps modulo 2^16.

Function
REQ-014 Two-state FSM, IDLE and RESP; reqN_ready SHALL be asserted only in IDLE, and only for the granted requester.
REQ-015 In IDLE, one valid requester is granted; if both are valid, the requester not granted last is granted (round-robin); with none valid, FSM stays in IDLE.
REQ-016 Grant = valid && ready handshake; in that same edge, operands are computed, the result is registered into rsp_res, rsp_id gets the index, and the FSM moves to RESP.
REQ-017 Latency: rsp_valid is asserted exactly 1 cycle after the accepting edge; throughput is at most one operation per 2 cycles.
REQ-018 In RESP, rsp_valid=1 and rsp_res, rsp_id stay stable until rsp_valid && rsp_ready; on that edge the FSM returns to IDLE and op_count increments.
REQ-019 A requester's valid is not consulted while the FSM is in RESP; deasserting it in RESP has no effect.
REQ-020 Arithmetic: mode 0 a&b; mode 1 a|b; mode 2 a+b when b_invert=0, a+~b+1 when b_invert=1; carry-out is discarded (modulo 2^WIDTH).
REQ-021 Mode 3 (SLT): result = zero-extended bit WIDTH-1 of (a+~b+1); there is no overflow correction, and b_invert is ignored.
REQ-022 op_count wraps 0xFFFF -> 0x0000 with no flag.
REQ-023 The round-robin pointer (last_grant) updates only on a handshake, never on an idle cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force: FSM=IDLE, rsp_valid=0, rsp_id=0, rsp_res=0, op_count=0, last_grant=1 (requester 0 wins the first contention).
REQ-025 Reset asserted in RESP drops the held result without incrementing op_count; req ready outputs are 0 while rst_n is low.

Structure
REQ-026 A shared package SHALL hold the mode encodings (MODE_AND=0, MODE_OR=1, MODE_ADD=2, MODE_SLT=3) and the FSM state type.
REQ-027 The combinational operation logic SHALL be a sub-module alu_core (inputs a, b, b_invert, mode; output res) instantiated once, fed by the granted requester's mux.

Verification
REQ-028 Reset, then only req0 valid: mode 2, a=5, b=3, b_invert=1, rsp_ready=1 -> rsp_valid the next cycle, rsp_res=2, rsp_id=0, op_count=1.
REQ-029 Both valid after reset -> req0 granted first, then req1 on the next IDLE; held continuously, grants alternate 0,1,0,1.
REQ-030 SLT: a=0x00000001, b=0x00000002 -> res=1; a=2, b=1 -> res=0; a=0x80000000, b=1 -> res=0 (documents no overflow correction).
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_res and rsp_id stable, both req ready outputs 0, op_count unchanged; rsp_ready=1 -> IDLE on the next edge.
REQ-032 ADD wrap: a=0xFFFFFFFF, b=1, b_invert=0 -> res=0; op_count preloaded by 65536 handshakes -> reads 0.
REQ-033 rst_n asserted mid-RESP -> rsp_valid falls immediately (asynchronous); after release, op_count=0 and requester 0 wins contention.
